router_out_sched: RTL

Packet-granular round-robin scheduler that drains the router's three output FIFOs (channels 0/1/2) onto one shared downstream byte link using a valid/ready handshake. Once a channel is granted, that grant is held until the whole packet has been transferred (header, payload and parity). A stall watchdog raises the per-channel soft_rst_x, which the router_fsm and FIFOs already consume, when a granted packet makes no progress.

---
 rtl/router_out_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/router_out_sched.sv
// Packet-granular round-robin drain of the three router output FIFOs onto one
// shared valid/ready byte link, with a per-packet stall watchdog.
module router_out_sched #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  input  logic       out_ready,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] data_out,
  output logic       vld_out,
  output logic       soft_rst_0,
  output logic       soft_rst_1,
  output logic       soft_rst_2,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, XFER_HDR, XFER_BODY} state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       g;
  logic [1:0]       last_grant;
  logic [6:0]       remaining;
  logic [CNT_W-1:0] stall_cnt;
  logic [2:0]       soft_rst_q;

  logic             xfer;
  logic             sel_empty;
  logic [7:0]       sel_data;
  logic             pop;
  logic [3:0]       empty_v;
  logic             found;
  logic [1:0]       pick;
  logic [1:0]       cand;

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c >= 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  assign xfer    = (state != IDLE);
  assign empty_v = {1'b1, fifo_empty_2, fifo_empty_1, fifo_empty_0};

  always_comb begin
    sel_empty = fifo_empty_2;
    sel_data  = data_in_2;
    case (g)
      2'd0: begin
        sel_empty = fifo_empty_0;
        sel_data  = data_in_0;
      end
      2'd1: begin
        sel_empty = fifo_empty_1;
        sel_data  = data_in_1;
      end
      default: ;
    endcase
  end

  assign vld_out    = xfer & ~sel_empty;
  assign pop        = vld_out & out_ready;
  assign data_out   = xfer ? sel_data : 8'h00;
  assign read_enb_0 = pop & (g == 2'd0);
  assign read_enb_1 = pop & (g == 2'd1);
  assign read_enb_2 = pop & (g == 2'd2);
  assign grant      = xfer ? g : 2'b11;
  assign busy       = xfer;
  assign soft_rst_0 = soft_rst_q[0];
  assign soft_rst_1 = soft_rst_q[1];
  assign soft_rst_2 = soft_rst_q[2];

  // Rotating search starting just after the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = next_ch(last_grant);
    for (int i = 0; i < 3; i++) begin
      if (!found && !empty_v[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = next_ch(cand);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      g          <= 2'd0;
      last_grant <= 2'd2;
      remaining  <= 7'd0;
      stall_cnt  <= '0;
      soft_rst_q <= 3'b000;
    end else begin
      soft_rst_q <= 3'b000;
      case (state)
        IDLE: begin
          if (found) begin
            g          <= pick;
            last_grant <= pick;
            stall_cnt  <= '0;
            state      <= XFER_HDR;
          end
        end
        XFER_HDR, XFER_BODY: begin
          if (pop) begin
            stall_cnt <= '0;
            if (state == XFER_HDR) begin
              // Payload length plus the trailing parity byte.
              remaining <= {1'b0, sel_data[7:2]} + 7'd1;
              state     <= XFER_BODY;
            end else begin
              remaining <= remaining - 7'd1;
              if (remaining == 7'd1) state <= IDLE;
            end
          end else if (stall_cnt == STALL_MAX) begin
            // Abort: last_grant keeps g so this channel is served last next time.
            state         <= IDLE;
            stall_cnt     <= '0;
            soft_rst_q[g] <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
